// File: rtl/prog_mem_pkg.sv
// Shared types for the program-memory read controller.
package prog_mem_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEM_REQ = 2'd1,
      RESPOND = 2'd2
   } ctrl_state_t;

   // A single consumer still needs a 1-bit index so every vector has a legal width.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible consumer at or after the pointer.
module rr_arbiter
   import prog_mem_pkg::*;
#(
   parameter int NUM_CONSUMERS = 4,
   parameter int IDX_W         = 2
) (
   input  logic [NUM_CONSUMERS-1:0] eligible,
   input  logic [IDX_W-1:0]         pointer,
   output logic                     grant_valid,
   output logic [IDX_W-1:0]         grant_idx
);

   generate
      if (NUM_CONSUMERS == 1) begin : g_single
         assign grant_valid = eligible[0];
         assign grant_idx   = '0;
      end else begin : g_rr
         always_comb begin
            logic [IDX_W-1:0] cand;
            grant_valid = 1'b0;
            grant_idx   = '0;
            cand        = '0;
            for (int off = 0; off < NUM_CONSUMERS; off++) begin
               cand = IDX_W'((int'(pointer) + off) % NUM_CONSUMERS);
               if (!grant_valid && eligible[cand]) begin
                  grant_valid = 1'b1;
                  grant_idx   = cand;
               end
            end
         end
      end
   endgenerate

endmodule

// File: rtl/prog_mem_controller.sv
// Serializes per-core fetch requests onto one program-memory read port,
// round-robin, returning each word with a one-cycle get pulse.
module prog_mem_controller
   import prog_mem_pkg::*;
#(
   parameter int NUM_CONSUMERS = 4,
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 16
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [NUM_CONSUMERS-1:0]                 consumer_read_ask,
   input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]                 consumer_read_get,
   output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
   output logic                                     mem_read_valid,
   output logic [ADDR_BITS-1:0]                     mem_read_address,
   input  logic                                     mem_read_ready,
   input  logic [DATA_BITS-1:0]                     mem_read_data
);

   localparam int IDX_W = idx_width(NUM_CONSUMERS);

   ctrl_state_t              state;
   logic [IDX_W-1:0]         idx;
   logic [IDX_W-1:0]         ptr;
   logic [IDX_W-1:0]         ptr_next;
   logic [IDX_W-1:0]         gnt_idx;
   logic                     gnt_valid;
   logic [NUM_CONSUMERS-1:0] served;
   logic [NUM_CONSUMERS-1:0] served_set;
   logic [NUM_CONSUMERS-1:0] eligible;

   // A served consumer stays blocked until it drops ask, so a held ask is not re-served.
   assign eligible = consumer_read_ask & ~served;
   assign ptr_next = (int'(idx) == NUM_CONSUMERS - 1) ? '0 : idx + 1'b1;

   always_comb begin
      served_set = '0;
      if (state == MEM_REQ && mem_read_ready)
         served_set[idx] = 1'b1;
   end

   rr_arbiter #(
      .NUM_CONSUMERS (NUM_CONSUMERS),
      .IDX_W         (IDX_W)
   ) u_arb (
      .eligible    (eligible),
      .pointer     (ptr),
      .grant_valid (gnt_valid),
      .grant_idx   (gnt_idx)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= IDLE;
         idx                <= '0;
         ptr                <= '0;
         served             <= '0;
         consumer_read_get  <= '0;
         consumer_read_data <= '0;
         mem_read_valid     <= 1'b0;
         mem_read_address   <= '0;
      end else begin
         // Clearing on a low ask wins, so a request dropped mid-flight leaves no stale block.
         served            <= consumer_read_ask & (served | served_set);
         consumer_read_get <= '0;
         case (state)
            IDLE: begin
               if (gnt_valid) begin
                  idx              <= gnt_idx;
                  mem_read_address <= consumer_read_address[gnt_idx];
                  mem_read_valid   <= 1'b1;
                  state            <= MEM_REQ;
               end
            end
            MEM_REQ: begin
               if (mem_read_ready) begin
                  consumer_read_data[idx] <= mem_read_data;
                  consumer_read_get[idx]  <= 1'b1;
                  mem_read_valid          <= 1'b0;
                  ptr                     <= ptr_next;
                  state                   <= RESPOND;
               end
            end
            RESPOND: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_mem_controller.sv
// Bench for prog_mem_controller: directed scenarios plus randomized fetchers
// checked against a round-robin queue model.
module tb_prog_mem_controller;

   localparam int N  = 4;
   localparam int AW = 8;
   localparam int DW = 16;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic [N-1:0]         ask = '0;
   logic [N-1:0][AW-1:0] ask_addr = '0;
   logic [N-1:0]         get;
   logic [N-1:0][DW-1:0] cdata;
   logic                 valid;
   logic [AW-1:0]        maddr;
   logic                 ready = 1'b0;
   logic [DW-1:0]        mdata = '0;

   int n_checks = 0;
   int n_pass   = 0;

   logic [DW-1:0] mem [256];
   int  mem_delay  = 0;
   int  wait_cnt   = 0;
   bit  rand_delay = 1'b0;

   prog_mem_controller #(
      .NUM_CONSUMERS (N),
      .ADDR_BITS     (AW),
      .DATA_BITS     (DW)
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .consumer_read_ask     (ask),
      .consumer_read_address (ask_addr),
      .consumer_read_get     (get),
      .consumer_read_data    (cdata),
      .mem_read_valid        (valid),
      .mem_read_address      (maddr),
      .mem_read_ready        (ready),
      .mem_read_data         (mdata)
   );

   always #5 clk = ~clk;

   // Memory responder: answers a pending request after mem_delay waiting cycles.
   always @(negedge clk) begin
      if (ready) begin
         ready = 1'b0;
      end else if (valid) begin
         if (wait_cnt >= mem_delay) begin
            ready    = 1'b1;
            mdata    = mem[maddr];
            wait_cnt = 0;
            if (rand_delay) mem_delay = $urandom_range(0, 3);
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      ask   = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ask   = '0;
      repeat (2) @(negedge clk);
      n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else n_pass++;
      n_checks++; if (maddr !== '0) $display("FAIL reset_addr got %h want 00", maddr); else n_pass++;
      n_checks++; if (get !== '0) $display("FAIL reset_get got %b want 0000", get); else n_pass++;
      n_checks++; if (cdata !== '0) $display("FAIL reset_data got %h want 0", cdata); else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_single();
      mem[8'h05]  = 16'h1234;
      mem_delay   = 0;
      ask[0]      = 1'b1;
      ask_addr[0] = 8'h05;
      @(negedge clk);
      n_checks++; if (valid !== 1'b1) $display("FAIL single_valid got %b want 1", valid); else n_pass++;
      n_checks++; if (maddr !== 8'h05) $display("FAIL single_addr got %h want 05", maddr); else n_pass++;
      n_checks++; if (get !== 4'b0000) $display("FAIL single_early_get got %b want 0000", get); else n_pass++;
      @(negedge clk);
      n_checks++; if (valid !== 1'b0) $display("FAIL single_valid_drop got %b want 0", valid); else n_pass++;
      n_checks++; if (get !== 4'b0001) $display("FAIL single_get got %b want 0001", get); else n_pass++;
      n_checks++; if (cdata[0] !== 16'h1234) $display("FAIL single_data got %h want 1234", cdata[0]); else n_pass++;
      ask[0] = 1'b0;
      @(negedge clk);
      n_checks++; if (get !== 4'b0000) $display("FAIL single_get_len got %b want 0000", get); else n_pass++;
   endtask

   task automatic test_all_four();
      logic [AW-1:0] order[$];
      int  gets[N];
      int  done = 0;
      int  cyc  = 0;
      bit  prev_v = 1'b0;
      do_reset();
      mem_delay = 0;
      for (int i = 0; i < N; i++) begin
         gets[i]     = 0;
         ask_addr[i] = AW'(8'h10 + i);
         ask[i]      = 1'b1;
      end
      while (done < N && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (valid && !prev_v) order.push_back(maddr);
         prev_v = valid;
         if (get != '0) begin
            n_checks++; if (!$onehot(get)) $display("FAIL all4_onehot got %b", get); else n_pass++;
            for (int i = 0; i < N; i++) if (get[i]) begin
               gets[i]++;
               done++;
               ask[i] = 1'b0;
               n_checks++;
               if (cdata[i] !== mem[8'h10 + i]) $display("FAIL all4_data[%0d] got %h want %h", i, cdata[i], mem[8'h10 + i]);
               else n_pass++;
            end
         end
      end
      n_checks++; if (order.size() != N) $display("FAIL all4_grants got %0d want %0d", order.size(), N); else n_pass++;
      for (int k = 0; k < N && k < order.size(); k++) begin
         n_checks++;
         if (order[k] !== AW'(8'h10 + k)) $display("FAIL all4_order[%0d] got %h want %h", k, order[k], 8'h10 + k);
         else n_pass++;
      end
      for (int i = 0; i < N; i++) begin
         n_checks++; if (gets[i] != 1) $display("FAIL all4_getcount[%0d] got %0d want 1", i, gets[i]); else n_pass++;
      end
   endtask

   task automatic test_wait_states();
      int cyc  = 0;
      int vcnt = 0;
      bit stable = 1'b1;
      do_reset();
      mem_delay   = 5;
      ask[1]      = 1'b1;
      ask_addr[1] = 8'h33;
      while (get == '0 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (valid) begin
            vcnt++;
            if (maddr !== 8'h33) stable = 1'b0;
         end
      end
      n_checks++; if (get !== 4'b0010) $display("FAIL wait_get got %b want 0010", get); else n_pass++;
      n_checks++; if (vcnt != 6) $display("FAIL wait_valid_cycles got %0d want 6", vcnt); else n_pass++;
      n_checks++; if (stable !== 1'b1) $display("FAIL wait_addr_stable got %b want 1", stable); else n_pass++;
      n_checks++; if (cdata[1] !== mem[8'h33]) $display("FAIL wait_data got %h want %h", cdata[1], mem[8'h33]); else n_pass++;
      ask[1]    = 1'b0;
      mem_delay = 0;
      @(negedge clk);
   endtask

   task automatic test_hold_ask();
      int cyc   = 0;
      int extra = 0;
      mem_delay   = 0;
      ask[2]      = 1'b1;
      ask_addr[2] = 8'h42;
      while (get == '0 && cyc < 20) begin @(negedge clk); cyc++; end
      n_checks++; if (get !== 4'b0100) $display("FAIL hold_first_get got %b want 0100", get); else n_pass++;
      n_checks++; if (cdata[2] !== mem[8'h42]) $display("FAIL hold_first_data got %h want %h", cdata[2], mem[8'h42]); else n_pass++;
      repeat (6) begin
         @(negedge clk);
         if (get != '0 || valid) extra++;
      end
      n_checks++; if (extra != 0) $display("FAIL hold_reserve got %0d busy cycles want 0", extra); else n_pass++;
      ask[2] = 1'b0;
      @(negedge clk);
      ask[2]      = 1'b1;
      ask_addr[2] = 8'h43;
      cyc = 0;
      while (get == '0 && cyc < 20) begin @(negedge clk); cyc++; end
      n_checks++; if (get !== 4'b0100) $display("FAIL hold_second_get got %b want 0100", get); else n_pass++;
      n_checks++; if (cdata[2] !== mem[8'h43]) $display("FAIL hold_second_data got %h want %h", cdata[2], mem[8'h43]); else n_pass++;
      ask[2] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int cyc = 0;
      mem_delay   = 20;
      ask[3]      = 1'b1;
      ask_addr[3] = 8'h77;
      while (!valid && cyc < 10) begin @(negedge clk); cyc++; end
      n_checks++; if (valid !== 1'b1) $display("FAIL rmid_grant got %b want 1", valid); else n_pass++;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_checks++; if (valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", valid); else n_pass++;
      n_checks++; if (maddr !== '0) $display("FAIL rmid_addr got %h want 00", maddr); else n_pass++;
      n_checks++; if (get !== '0 || cdata !== '0) $display("FAIL rmid_outs got get=%b data=%h want 0", get, cdata); else n_pass++;
      reset       = 1'b0;
      mem_delay   = 0;
      ask[1]      = 1'b1;
      ask_addr[1] = 8'h21;
      ask_addr[3] = 8'h78;
      cyc = 0;
      while (!valid && cyc < 10) begin @(negedge clk); cyc++; end
      n_checks++; if (maddr !== 8'h21) $display("FAIL rmid_ptr0 got %h want 21", maddr); else n_pass++;
      cyc = 0;
      while (ask != '0 && cyc < 30) begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < N; i++) if (get[i]) ask[i] = 1'b0;
      end
      n_checks++; if (cdata[1] !== mem[8'h21]) $display("FAIL rmid_data1 got %h want %h", cdata[1], mem[8'h21]); else n_pass++;
      n_checks++; if (cdata[3] !== mem[8'h78]) $display("FAIL rmid_data3 got %h want %h", cdata[3], mem[8'h78]); else n_pass++;
   endtask

   task automatic test_fairness();
      int  grants[$];
      bit  rearm[N];
      int  cyc = 0;
      bit  prev_v = 1'b0;
      do_reset();
      mem_delay = 0;
      for (int i = 0; i < N; i++) rearm[i] = 1'b0;
      ask_addr[0] = {2'd0, 6'($urandom)};
      ask_addr[3] = {2'd3, 6'($urandom)};
      ask[0] = 1'b1;
      ask[3] = 1'b1;
      while (grants.size() < 8 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < N; i++) if (rearm[i]) begin
            ask_addr[i] = {2'(i), 6'($urandom)};
            ask[i]      = 1'b1;
            rearm[i]    = 1'b0;
         end
         if (valid && !prev_v) grants.push_back(int'(maddr[7:6]));
         prev_v = valid;
         for (int i = 0; i < N; i++) if (get[i]) begin ask[i] = 1'b0; rearm[i] = 1'b1; end
      end
      ask = '0;
      repeat (8) @(negedge clk);
      n_checks++; if (grants.size() != 8) $display("FAIL fair_count got %0d want 8", grants.size()); else n_pass++;
      for (int k = 0; k < grants.size(); k++) begin
         n_checks++;
         if (grants[k] != ((k % 2) ? 3 : 0)) $display("FAIL fair_seq[%0d] got %0d want %0d", k, grants[k], (k % 2) ? 3 : 0);
         else n_pass++;
      end
   endtask

   // Reference: each fetcher has at most one outstanding request; a new grant must be
   // the first pending fetcher at or after the slot following the last one served.
   task automatic test_random();
      bit                   pending[N];
      int                   gap[N];
      logic [N-1:0][DW-1:0] exp_data;
      int  mptr = 0;
      int  inflight = -1;
      int  served_cnt = 0;
      int  exp_i;
      int  cyc = 0;
      bit  any_pend = 1'b1;
      do_reset();
      rand_delay = 1'b1;
      mem_delay  = 0;
      exp_data   = '0;
      for (int i = 0; i < N; i++) begin pending[i] = 1'b0; gap[i] = $urandom_range(0, 3); end
      while (cyc < 700 && (cyc < 400 || any_pend || inflight >= 0)) begin
         @(negedge clk);
         cyc++;
         if (get != '0) begin
            n_checks++;
            if (inflight < 0 || get !== (N'(1) << inflight)) $display("FAIL rnd_get got %b inflight %0d", get, inflight);
            else n_pass++;
            if (inflight >= 0) begin
               exp_data[inflight] = mem[ask_addr[inflight]];
               pending[inflight]  = 1'b0;
               ask[inflight]      = 1'b0;
               gap[inflight]      = $urandom_range(1, 4);
               mptr               = (inflight + 1) % N;
               inflight           = -1;
               served_cnt++;
            end
            n_checks++; if (cdata !== exp_data) $display("FAIL rnd_data got %h want %h", cdata, exp_data); else n_pass++;
            n_checks++; if (valid !== 1'b0) $display("FAIL rnd_valid_after_get got %b want 0", valid); else n_pass++;
         end else if (valid) begin
            if (inflight < 0) begin
               exp_i = -1;
               for (int off = 0; off < N; off++)
                  if (exp_i < 0 && pending[(mptr + off) % N]) exp_i = (mptr + off) % N;
               n_checks++;
               if (exp_i < 0 || maddr !== ask_addr[exp_i]) $display("FAIL rnd_grant got %h want consumer %0d", maddr, exp_i);
               else n_pass++;
               inflight = (exp_i < 0) ? int'(maddr[7:6]) : exp_i;
            end else begin
               n_checks++;
               if (maddr !== ask_addr[inflight]) $display("FAIL rnd_addr_hold got %h want %h", maddr, ask_addr[inflight]);
               else n_pass++;
            end
         end
         any_pend = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (!pending[i] && cyc < 400) begin
               if (gap[i] > 0) gap[i]--;
               else begin
                  ask_addr[i] = {2'(i), 6'($urandom)};
                  ask[i]      = 1'b1;
                  pending[i]  = 1'b1;
               end
            end
            if (pending[i]) any_pend = 1'b1;
         end
      end
      n_checks++; if (any_pend || inflight >= 0) $display("FAIL rnd_drain got pending=%b inflight=%0d", any_pend, inflight); else n_pass++;
      n_checks++; if (served_cnt < 20) $display("FAIL rnd_throughput got %0d services want >=20", served_cnt); else n_pass++;
      rand_delay = 1'b0;
      mem_delay  = 0;
      ask        = '0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
      test_reset();
      test_single();
      test_all_four();
      test_wait_states();
      test_hold_ask();
      test_reset_mid();
      test_fairness();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
